// File: rtl/conv2d_pkg.sv
// Shared types and fixed-point helpers for the sequential conv2d engine.
package conv2d_pkg;

  localparam int ACC_W_DEF = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_e;

  // Full-precision Q-format product, rescaled back to the data Q format.
  function automatic logic signed [31:0] mul_shift(input logic signed [15:0] a,
                                                   input logic signed [15:0] b,
                                                   input int frac);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return p >>> frac;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)  return 16'sh7fff;
    if (v < -64'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/conv2d_mac.sv
// Single multiply-accumulate slice; the first product of a window is added
// onto the channel bias instead of the running sum.
module conv2d_mac
  import conv2d_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAC_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    ld_i,
  input  logic signed [15:0]      px_i,
  input  logic signed [15:0]      wt_i,
  input  logic signed [15:0]      bias_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, base, prod;

  always_comb begin
    prod  = ACC_W'(mul_shift(px_i, wt_i, FRAC_BITS));
    base  = ld_i ? ACC_W'(bias_i) : acc_q;
    acc_d = en_i ? base + prod : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv2d_seq_engine.sv
// Sequential 2D convolution: one pixel*weight product per cycle, one output
// beat per (x, y, channel) handed out over a ready/valid port.
module conv2d_seq_engine
  import conv2d_pkg::*;
#(
  parameter  int IN_W      = 64,
  parameter  int IN_H      = 64,
  parameter  int IN_CH     = 1,
  parameter  int K         = 3,
  parameter  int OUT_CH    = 30,
  parameter  int STRIDE    = 1,
  parameter  int FRAC_BITS = 8,
  parameter  int ACC_W     = ACC_W_DEF,
  localparam int OUT_W     = (IN_W - K) / STRIDE + 1,
  localparam int OUT_H     = (IN_H - K) / STRIDE + 1,
  localparam int NWT       = OUT_CH * IN_CH * K * K,
  localparam int NPX       = IN_W * IN_H * IN_CH,
  localparam int WA_W      = (NWT > 1) ? $clog2(NWT) : 1,
  localparam int BA_W      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int PA_W      = (NPX > 1) ? $clog2(NPX) : 1,
  localparam int OX_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int OY_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int KC_W      = (K > 1) ? $clog2(K) : 1,
  localparam int CC_W      = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   relu_en,
  output logic                   busy,
  output logic                   done,
  input  logic                   wt_we,
  input  logic [WA_W-1:0]        wt_addr,
  input  logic signed [15:0]     wt_data,
  input  logic                   bias_we,
  input  logic [BA_W-1:0]        bias_addr,
  input  logic signed [15:0]     bias_data,
  output logic                   px_rd,
  output logic [PA_W-1:0]        px_addr,
  input  logic signed [15:0]     px_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [15:0]     out_data,
  output logic [OX_W-1:0]        out_x,
  output logic [OY_W-1:0]        out_y,
  output logic [BA_W-1:0]        out_ch
);

  state_e             state_q;
  logic [KC_W-1:0]    kx_q, ky_q;
  logic [CC_W-1:0]    c_q;
  logic [OX_W-1:0]    ox_q;
  logic [OY_W-1:0]    oy_q;
  logic [BA_W-1:0]    n_q;
  logic               relu_q, out_valid_q, rd_dly_q, first_dly_q;
  logic               last_tap, last_beat;
  int                 px_idx, wt_idx;

  logic signed [15:0] wt_mem   [NWT];
  logic signed [15:0] bias_mem [OUT_CH];
  logic signed [15:0] wt_q, bias_rd;
  logic signed [ACC_W-1:0] acc, acc_r;

  assign last_tap  = (kx_q == KC_W'(K - 1)) && (ky_q == KC_W'(K - 1)) &&
                     (c_q == CC_W'(IN_CH - 1));
  assign last_beat = (n_q == BA_W'(OUT_CH - 1)) && (ox_q == OX_W'(OUT_W - 1)) &&
                     (oy_q == OY_W'(OUT_H - 1));

  always_comb begin
    px_idx = ((int'(oy_q) * STRIDE + int'(ky_q)) * IN_W + int'(ox_q) * STRIDE +
              int'(kx_q)) * IN_CH + int'(c_q);
    wt_idx = ((int'(n_q) * IN_CH + int'(c_q)) * K + int'(ky_q)) * K + int'(kx_q);
  end

  // Coefficient storage survives reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && wt_we && int'(wt_addr) < NWT)
      wt_mem[wt_addr] <= wt_data;
    if (state_q == S_IDLE && bias_we && int'(bias_addr) < OUT_CH)
      bias_mem[bias_addr] <= bias_data;
    wt_q <= wt_mem[WA_W'(wt_idx)];
  end

  assign bias_rd = bias_mem[n_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      kx_q        <= '0;
      ky_q        <= '0;
      c_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      n_q         <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      first_dly_q <= 1'b0;
    end else begin
      // px_data and wt_q for a read issued this cycle arrive next cycle.
      rd_dly_q    <= (state_q == S_MAC);
      first_dly_q <= (state_q == S_MAC) && kx_q == '0 && ky_q == '0 && c_q == '0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_MAC;
          relu_q  <= relu_en;
        end
        S_MAC: begin
          if (last_tap) state_q <= S_DRAIN;
          if (kx_q == KC_W'(K - 1)) begin
            kx_q <= '0;
            if (ky_q == KC_W'(K - 1)) begin
              ky_q <= '0;
              c_q  <= (c_q == CC_W'(IN_CH - 1)) ? '0 : c_q + 1'b1;
            end else ky_q <= ky_q + 1'b1;
          end else kx_q <= kx_q + 1'b1;
        end
        S_DRAIN: begin
          state_q     <= S_OUTPUT;
          out_valid_q <= 1'b1;
        end
        S_OUTPUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (last_beat) begin
            state_q <= S_DONE;
            n_q     <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
          end else begin
            state_q <= S_MAC;
            if (n_q == BA_W'(OUT_CH - 1)) begin
              n_q <= '0;
              if (ox_q == OX_W'(OUT_W - 1)) begin
                ox_q <= '0;
                oy_q <= oy_q + 1'b1;
              end else ox_q <= ox_q + 1'b1;
            end else n_q <= n_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  conv2d_mac #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (rd_dly_q),
    .ld_i   (first_dly_q),
    .px_i   (px_data),
    .wt_i   (wt_q),
    .bias_i (bias_rd),
    .acc_o  (acc)
  );

  // Accumulator is frozen in OUTPUT, so the beat holds while stalled.
  assign acc_r     = (relu_q && acc[ACC_W-1]) ? '0 : acc;
  assign out_data  = sat16(64'(acc_r));
  assign out_valid = out_valid_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_ch    = n_q;
  assign px_rd     = (state_q == S_MAC);
  assign px_addr   = PA_W'(px_idx);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Directed bench: a 4x4/K3 engine for function, saturation, reset and busy
// rules, and a 5x5/K3/stride-2/two-channel engine for ordering and stalls.
module tb_conv2d_seq_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic               a_start = 0, a_relu = 0, a_wt_we = 0, a_bias_we = 0, a_or = 0;
  logic [3:0]         a_wt_addr = 0;
  logic [0:0]         a_bias_addr = 0;
  logic signed [15:0] a_wt_data = 0, a_bias_data = 0;
  logic               a_busy, a_done, a_px_rd, a_ov;
  logic [3:0]         a_px_addr;
  logic signed [15:0] a_px_data = 0, a_od;
  logic [0:0]         a_ox, a_oy, a_oc;
  logic signed [15:0] a_pmem [16];
  int                 a_done_cnt = 0;

  logic               b_start = 0, b_relu = 0, b_wt_we = 0, b_bias_we = 0, b_or = 0;
  logic [4:0]         b_wt_addr = 0;
  logic [0:0]         b_bias_addr = 0;
  logic signed [15:0] b_wt_data = 0, b_bias_data = 0;
  logic               b_busy, b_done, b_px_rd, b_ov;
  logic [4:0]         b_px_addr;
  logic signed [15:0] b_px_data = 0, b_od;
  logic [0:0]         b_ox, b_oy, b_oc;
  logic signed [15:0] b_pmem [25];
  int                 b_done_cnt = 0, b_hs = 0;
  int                 bexp [8];

  conv2d_seq_engine #(.IN_W(4), .IN_H(4), .IN_CH(1), .K(3), .OUT_CH(1), .STRIDE(1)) ua (
    .clk(clk), .reset(reset), .start(a_start), .relu_en(a_relu), .busy(a_busy), .done(a_done),
    .wt_we(a_wt_we), .wt_addr(a_wt_addr), .wt_data(a_wt_data),
    .bias_we(a_bias_we), .bias_addr(a_bias_addr), .bias_data(a_bias_data),
    .px_rd(a_px_rd), .px_addr(a_px_addr), .px_data(a_px_data),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_x(a_ox), .out_y(a_oy), .out_ch(a_oc));

  conv2d_seq_engine #(.IN_W(5), .IN_H(5), .IN_CH(1), .K(3), .OUT_CH(2), .STRIDE(2)) ub (
    .clk(clk), .reset(reset), .start(b_start), .relu_en(b_relu), .busy(b_busy), .done(b_done),
    .wt_we(b_wt_we), .wt_addr(b_wt_addr), .wt_data(b_wt_data),
    .bias_we(b_bias_we), .bias_addr(b_bias_addr), .bias_data(b_bias_data),
    .px_rd(b_px_rd), .px_addr(b_px_addr), .px_data(b_px_data),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_x(b_ox), .out_y(b_oy), .out_ch(b_oc));

  // Pixel sources answer one cycle after a read; garbage when not read.
  always @(posedge clk) begin
    a_px_data <= a_px_rd ? a_pmem[a_px_addr] : 16'sh5a5a;
    b_px_data <= (b_px_rd && b_px_addr < 5'd25) ? b_pmem[b_px_addr] : 16'sh5a5a;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_ov && b_or) b_hs <= b_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic a_wt(input int addr, input logic signed [15:0] d);
    a_wt_we = 1; a_wt_addr = 4'(addr); a_wt_data = d;
    tick();
    a_wt_we = 0;
  endtask

  task automatic a_bias(input logic signed [15:0] d);
    a_bias_we = 1; a_bias_addr = 0; a_bias_data = d;
    tick();
    a_bias_we = 0;
  endtask

  task automatic a_go(input logic relu, input logic co_we, input logic signed [15:0] co_data);
    a_start = 1; a_relu = relu;
    if (co_we) begin a_wt_we = 1; a_wt_addr = 4'd4; a_wt_data = co_data; end
    tick();
    a_start = 0; a_wt_we = 0;
    chk("a.busy_after_start", 32'(a_busy), 1);
  endtask

  task automatic a_beat(input string tag, input int e, input int ex, input int ey, input int elat);
    int w = 0;
    while (a_ov !== 1'b1 && w < 100) begin tick(); w++; end
    chk({tag, ".lat"}, w, elat);
    chk({tag, ".data"}, 32'(a_od), e);
    chk({tag, ".x"}, 32'(a_ox), ex);
    chk({tag, ".y"}, 32'(a_oy), ey);
    chk({tag, ".ch"}, 32'(a_oc), 0);
    a_or = 1;
    tick();
    a_or = 0;
  endtask

  task automatic a_collect(input string tag, input int e [4], input int pre);
    int d0 = a_done_cnt;
    for (int i = 0; i < 4; i++)
      a_beat($sformatf("%s.b%0d", tag, i), e[i], i % 2, i / 2, (i == 0) ? 10 - pre : 10);
    chk({tag, ".done"}, 32'(a_done), 1);
    tick();
    chk({tag, ".busy_end"}, 32'(a_busy), 0);
    chk({tag, ".done_cnt"}, a_done_cnt - d0, 1);
  endtask

  task automatic b_wt(input int addr, input logic signed [15:0] d);
    b_wt_we = 1; b_wt_addr = 5'(addr); b_wt_data = d;
    tick();
    b_wt_we = 0;
  endtask

  task automatic b_bias(input int addr, input logic signed [15:0] d);
    b_bias_we = 1; b_bias_addr = 1'(addr); b_bias_data = d;
    tick();
    b_bias_we = 0;
  endtask

  // prob = percent chance of out_ready per cycle while a beat is offered.
  task automatic b_frame(input string tag, input int prob);
    int h0 = b_hs;
    int d0 = b_done_cnt;
    b_start = 1;
    tick();
    b_start = 0;
    for (int i = 0; i < 8; i++) begin
      int  w = 0;
      int  g = 0;
      logic hs = 0;
      string t = $sformatf("%s.b%0d", tag, i);
      while (b_ov !== 1'b1 && w < 100) begin tick(); w++; end
      chk({t, ".lat"}, w, 10);
      do begin
        b_or = ($urandom_range(0, 99) < prob);
        chk({t, ".valid"}, 32'(b_ov), 1);
        chk({t, ".data"}, 32'(b_od), bexp[i]);
        chk({t, ".x"}, 32'(b_ox), (i / 2) % 2);
        chk({t, ".y"}, 32'(b_oy), i / 4);
        chk({t, ".ch"}, 32'(b_oc), i % 2);
        hs = b_or && b_ov;
        tick();
        g++;
      end while (!hs && g < 200);
      b_or = 0;
      chk({t, ".handshake"}, 32'(hs), 1);
    end
    chk({tag, ".done"}, 32'(b_done), 1);
    tick();
    chk({tag, ".busy_end"}, 32'(b_busy), 0);
    chk({tag, ".beats"}, b_hs - h0, 8);
    chk({tag, ".done_cnt"}, b_done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dsave;
    for (int i = 0; i < 16; i++) a_pmem[i] = 16'(256 * i);
    for (int i = 0; i < 25; i++) b_pmem[i] = 16'(256 * i);
    bexp = '{13824, 1280, 18432, 1792, 32767, 3840, 32767, 4352};

    repeat (2) tick();
    chk("rst.busy", 32'(a_busy), 0);
    chk("rst.done", 32'(a_done), 0);
    chk("rst.valid", 32'(a_ov), 0);
    chk("rst.px_rd", 32'(a_px_rd), 0);
    chk("rst.px_addr", 32'(a_px_addr), 0);
    chk("rst.data", 32'(a_od), 0);
    chk("rst.b_valid", 32'(b_ov), 0);
    reset = 1;
    tick();

    // Centre tap 1.0: outputs reproduce the window centres 5, 6, 9, 10.
    for (int i = 0; i < 9; i++) a_wt(i, (i == 4) ? 16'sh0100 : 16'sh0000);
    a_bias(16'sh0000);
    a_go(0, 0, 0);
    a_collect("ctr", '{1280, 1536, 2304, 2560}, 0);

    // Centre tap -1.0 with bias 8.0: mixed-sign results, then ReLU'd.
    a_wt(4, 16'shFF00);
    a_bias(16'sh0800);
    a_go(0, 0, 0);
    a_collect("bias", '{768, 512, -256, -512}, 0);
    a_go(1, 0, 0);
    a_collect("relu", '{768, 512, 0, 0}, 0);

    // Weight written in the same cycle as start: frame sees 2.0.
    a_go(0, 1, 16'sh0200);
    a_collect("co_we", '{4608, 5120, 6656, 7168}, 0);

    // start / wt_we / bias_we while busy are dropped.
    a_go(0, 0, 0);
    a_start = 1; a_wt_we = 1; a_wt_addr = 4'd4; a_wt_data = 16'sh7FFF;
    a_bias_we = 1; a_bias_data = 16'sh1000;
    tick();
    a_start = 0; a_wt_we = 0; a_bias_we = 0;
    a_collect("poke", '{4608, 5120, 6656, 7168}, 1);
    a_go(0, 0, 0);
    a_collect("after_poke", '{4608, 5120, 6656, 7168}, 0);

    // Reset in the middle of the second beat's MAC phase.
    dsave = a_done_cnt;
    a_go(0, 0, 0);
    a_beat("mid.b0", 4608, 0, 0, 10);
    repeat (4) tick();
    chk("mid.px_rd_before", 32'(a_px_rd), 1);
    reset = 0;
    #1;
    chk("mid.busy", 32'(a_busy), 0);
    chk("mid.valid", 32'(a_ov), 0);
    chk("mid.px_rd", 32'(a_px_rd), 0);
    chk("mid.px_addr", 32'(a_px_addr), 0);
    chk("mid.data", 32'(a_od), 0);
    repeat (2) tick();
    reset = 1;
    tick();
    chk("mid.no_done", a_done_cnt - dsave, 0);
    a_go(0, 0, 0);
    a_collect("post_rst", '{4608, 5120, 6656, 7168}, 0);

    // Saturation at both rails, and ReLU on the negative rail.
    for (int i = 0; i < 9; i++) a_wt(i, 16'sh7FFF);
    a_bias(16'sh0000);
    for (int i = 0; i < 16; i++) a_pmem[i] = 16'sh7FFF;
    a_go(0, 0, 0);
    a_collect("sat_pos", '{32767, 32767, 32767, 32767}, 0);
    for (int i = 0; i < 16; i++) a_pmem[i] = 16'sh8000;
    a_go(0, 0, 0);
    a_collect("sat_neg", '{-32768, -32768, -32768, -32768}, 0);
    a_go(1, 0, 0);
    a_collect("sat_relu", '{0, 0, 0, 0}, 0);

    // Stride-2, two channels: box sum on ch0, centre minus 1.0 on ch1.
    for (int i = 0; i < 18; i++) b_wt(i, (i < 9 || i == 13) ? 16'sh0100 : 16'sh0000);
    b_bias(0, 16'sh0000);
    b_bias(1, 16'shFF00);
    b_frame("stride", 100);
    b_frame("stall", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
